int_dp_sequencer: RTL
=====================

INT_DP_SEQUENCER -- requirements
Module: int_dp_sequencer

Interface
REQ-001 Parameter: OP_W, default 3, width of op_class.
REQ-002 Clock and reset SHALL be: clk, asynchronous active-high reset named reset.
REQ-003 clk  in  1  rising-edge clock shared with the integer datapath.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req_valid  in  1  op request present; req_ready  out  1  sequencer can accept.
REQ-006 op_class  in  OP_W  0 ALU_R, 1 ALU_I, 2 MULDIV, 3 MFHI, 4 MFLO, 5 LDY, 6 LINK, 7 illegal.
REQ-007 fs  in  5  ALU function; shamt  in  5  shift amount; rs, rt, rd  in  5 each  register addresses.
REQ-008 imm  in  32  immediate/load data; pc  in  32  link value.
REQ-009 C, V, N, Z  in  1 each  datapath ALU flags.
REQ-010 S_Addr, T_Addr, D_Addr, FS, shift_val  out  5 each; DA_sel  out  2; Y_Sel  out  3.
REQ-011 D_En, T_Sel, HILO_LD  out  1 each; DT, DY, PC_in  out  32 each.
REQ-012 done  out  1  one-cycle completion pulse; err  out  1  with done for illegal op; flags  out  4  {C,V,N,Z} captured.

Function
REQ-013 States SHALL be IDLE, RD, EX, WB; req_ready=1 only in IDLE.
REQ-014 Accept on req_valid&req_ready; all request fields SHALL be registered at accept and held until return to IDLE.
REQ-015 ALU_R/ALU_I: IDLE->RD->EX->WB->IDLE; done in WB (3 cycles after accept).
REQ-016 RD: drive S_Addr=rs, T_Addr=rt; T_Sel=1 and DT=imm for ALU_I, else T_Sel=0.
REQ-017 EX: drive FS=fs, shift_val=shamt; flags SHALL latch {C,V,N,Z} at the end of EX.
REQ-018 WB for ALU ops: Y_Sel=000, D_En=1; DA_sel=00 (rd) for ALU_R, 01 (rt) for ALU_I.
REQ-019 MULDIV: IDLE->RD->EX->IDLE; HILO_LD=1 in EX only; done in EX; no D_En.
REQ-020 MFHI/MFLO: IDLE->WB; Y_Sel=001/010, DA_sel=00; done 1 cycle after accept.
REQ-021 LDY: IDLE->RD->WB; DY=imm driven in RD and WB; Y_Sel=011, DA_sel=01.
REQ-022 LINK: IDLE->WB; PC_in=pc, Y_Sel=100, DA_sel=10 (R31).
REQ-023 Illegal: IDLE->WB with D_En=0, HILO_LD=0; done=err=1.
REQ-024 D_En SHALL be suppressed when the selected destination address is 0 (DA_sel 00/01).
REQ-025 Outside the states named above: D_En=0, HILO_LD=0, Y_Sel=000, DA_sel=00, T_Sel=0.
REQ-026 MFHI/MFLO accepted immediately after MULDIV done SHALL read the new HI/LO.
REQ-027 Back-to-back ops SHALL be separated by at least one IDLE cycle.

Reset
REQ-028 On reset: state=IDLE, req_ready=1 after release, done=err=0, flags=0, D_En=HILO_LD=0, all address/data outputs 0.
REQ-029 Reset mid-op SHALL abort without any register or HI/LO write.

Structure
REQ-030 Package int_dp_seq_pkg SHALL hold op_class codes, state encoding, Y_Sel codes and DA_sel codes.
REQ-031 One sub-module int_dp_seq_decode (combinational op_class -> path/Y_Sel/DA_sel/T_Sel table) is natural.

Verification
REQ-032 ALU_R rs=1, rt=2, rd=3, fs=ADD -> RD/EX/WB; D_En=1, D_Addr=3, DA_sel=00 in cycle 3; done cycle 3.
REQ-033 ALU_I rt=5, imm=32'h0000_0010 -> T_Sel=1, DT=16 in RD; WB DA_sel=01, D_En=1.
REQ-034 MULDIV then MFLO rd=4 -> HILO_LD=1 only in MULDIV EX; MFLO WB Y_Sel=010, D_Addr=4.
REQ-035 LINK pc=32'h0040_0008 -> WB Y_Sel=100, DA_sel=10, PC_in=32'h0040_0008, done 1 cycle after accept.
REQ-036 ALU_R rd=0 -> D_En=0 in WB, done=1; op_class=7 -> done=err=1, no writes.
REQ-037 Reset asserted in EX of MULDIV -> HILO_LD=0, state IDLE, flags=0.

Source files
------------

// File: rtl/int_dp_seq_pkg.sv
// Shared definitions for the integer datapath sequencer.
// Holds the op_class codes, FSM state encoding, register-file write-data
// (Y_Sel) codes, destination-address (DA_sel) codes and the decoded
// per-op control bundle.
package int_dp_seq_pkg;

    localparam logic [2:0] OP_ALU_R  = 3'd0;
    localparam logic [2:0] OP_ALU_I  = 3'd1;
    localparam logic [2:0] OP_MULDIV = 3'd2;
    localparam logic [2:0] OP_MFHI   = 3'd3;
    localparam logic [2:0] OP_MFLO   = 3'd4;
    localparam logic [2:0] OP_LDY    = 3'd5;
    localparam logic [2:0] OP_LINK   = 3'd6;

    localparam logic [4:0] LINK_REG  = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        Y_ALU = 3'b000,
        Y_HI  = 3'b001,
        Y_LO  = 3'b010,
        Y_DY  = 3'b011,
        Y_PC  = 3'b100
    } y_sel_e;

    typedef enum logic [1:0] {
        DA_RD  = 2'b00,
        DA_RT  = 2'b01,
        DA_R31 = 2'b10
    } da_sel_e;

    // Which phases an op visits plus its static control values.
    typedef struct packed {
        logic    use_rd;
        logic    use_ex;
        logic    use_wb;
        logic    wr_en;
        logic    hilo_ld;
        logic    t_sel;
        logic    illegal;
        y_sel_e  y_sel;
        da_sel_e da_sel;
    } dec_t;

endpackage

// File: rtl/int_dp_seq_decode.sv
// Combinational op_class decoder.
// Ports:
//   op_class  in   OP_W  requested operation class
//   dec       out  dec_t phase path, write enable, HI/LO load, T_Sel,
//                        Y_Sel and DA_sel for that class
// Any code not listed (7, or wider codes when OP_W > 3) decodes as illegal:
// a single WB cycle that writes nothing.
module int_dp_seq_decode
    import int_dp_seq_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic [OP_W-1:0] op_class,
    output dec_t            dec
);

    always_comb begin
        dec         = '0;
        dec.use_wb  = 1'b1;
        dec.illegal = 1'b1;
        dec.y_sel   = Y_ALU;
        dec.da_sel  = DA_RD;
        case (op_class)
            OP_W'(OP_ALU_R): begin
                dec.illegal = 1'b0;
                dec.use_rd  = 1'b1;
                dec.use_ex  = 1'b1;
                dec.wr_en   = 1'b1;
            end
            OP_W'(OP_ALU_I): begin
                dec.illegal = 1'b0;
                dec.use_rd  = 1'b1;
                dec.use_ex  = 1'b1;
                dec.wr_en   = 1'b1;
                dec.t_sel   = 1'b1;
                dec.da_sel  = DA_RT;
            end
            OP_W'(OP_MULDIV): begin
                dec.illegal = 1'b0;
                dec.use_rd  = 1'b1;
                dec.use_ex  = 1'b1;
                dec.use_wb  = 1'b0;
                dec.hilo_ld = 1'b1;
            end
            OP_W'(OP_MFHI): begin
                dec.illegal = 1'b0;
                dec.wr_en   = 1'b1;
                dec.y_sel   = Y_HI;
            end
            OP_W'(OP_MFLO): begin
                dec.illegal = 1'b0;
                dec.wr_en   = 1'b1;
                dec.y_sel   = Y_LO;
            end
            OP_W'(OP_LDY): begin
                dec.illegal = 1'b0;
                dec.use_rd  = 1'b1;
                dec.wr_en   = 1'b1;
                dec.y_sel   = Y_DY;
                dec.da_sel  = DA_RT;
            end
            OP_W'(OP_LINK): begin
                dec.illegal = 1'b0;
                dec.wr_en   = 1'b1;
                dec.y_sel   = Y_PC;
                dec.da_sel  = DA_R31;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/int_dp_sequencer.sv
// Integer datapath sequencer: accepts one op request at a time and walks
// the datapath through register read (RD), execute (EX) and write-back (WB).
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid / req_ready         request handshake (ready only in IDLE)
//   op_class, fs, shamt, rs, rt,
//   rd, imm, pc                   request fields, captured at accept
//   C, V, N, Z                    ALU flags from the datapath
//   S_Addr, T_Addr, D_Addr        register-file addresses
//   FS, shift_val                 ALU function and shift amount
//   DA_sel, Y_Sel                 destination and write-data selects
//   D_En, T_Sel, HILO_LD          write enable, immediate select, HI/LO load
//   DT, DY, PC_in                 immediate, load data and link value
//   done, err                     completion pulse, illegal-op flag
//   flags                         {C,V,N,Z} captured at the end of EX
// All datapath-facing outputs are decoded from the current state, so an
// asynchronous reset lands in IDLE and drops every enable immediately.
module int_dp_sequencer
    import int_dp_seq_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] op_class,
    input  logic [4:0]      fs,
    input  logic [4:0]      shamt,
    input  logic [4:0]      rs,
    input  logic [4:0]      rt,
    input  logic [4:0]      rd,
    input  logic [31:0]     imm,
    input  logic [31:0]     pc,
    input  logic            C,
    input  logic            V,
    input  logic            N,
    input  logic            Z,
    output logic [4:0]      S_Addr,
    output logic [4:0]      T_Addr,
    output logic [4:0]      D_Addr,
    output logic [4:0]      FS,
    output logic [4:0]      shift_val,
    output logic [1:0]      DA_sel,
    output logic [2:0]      Y_Sel,
    output logic            D_En,
    output logic            T_Sel,
    output logic            HILO_LD,
    output logic [31:0]     DT,
    output logic [31:0]     DY,
    output logic [31:0]     PC_in,
    output logic            done,
    output logic            err,
    output logic [3:0]      flags
);

    state_e      state, state_n;
    dec_t        dec_in, dec_q;
    logic [4:0]  fs_q, shamt_q, rs_q, rt_q, rd_q;
    logic [31:0] imm_q, pc_q;
    logic [4:0]  dst;
    logic        accept;

    int_dp_seq_decode #(.OP_W(OP_W)) u_decode (
        .op_class (op_class),
        .dec      (dec_in)
    );

    assign accept = (state == ST_IDLE) && req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Request fields are only consumed outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            dec_q   <= dec_in;
            fs_q    <= fs;
            shamt_q <= shamt;
            rs_q    <= rs;
            rt_q    <= rt;
            rd_q    <= rd;
            imm_q   <= imm;
            pc_q    <= pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                flags <= 4'b0000;
        else if (state == ST_EX)  flags <= {C, V, N, Z};
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        S_Addr    = '0;
        T_Addr    = '0;
        D_Addr    = '0;
        FS        = '0;
        shift_val = '0;
        DA_sel    = DA_RD;
        Y_Sel     = Y_ALU;
        D_En      = 1'b0;
        T_Sel     = 1'b0;
        HILO_LD   = 1'b0;
        DT        = '0;
        DY        = '0;
        PC_in     = '0;
        done      = 1'b0;
        err       = 1'b0;
        dst       = rd_q;

        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = dec_in.use_rd ? ST_RD : ST_WB;
            end
            ST_RD: begin
                S_Addr = rs_q;
                T_Addr = rt_q;
                if (dec_q.t_sel) begin
                    T_Sel = 1'b1;
                    DT    = imm_q;
                end
                if (dec_q.y_sel == Y_DY) DY = imm_q;
                state_n = dec_q.use_ex ? ST_EX : ST_WB;
            end
            ST_EX: begin
                FS        = fs_q;
                shift_val = shamt_q;
                HILO_LD   = dec_q.hilo_ld;
                if (dec_q.use_wb) begin
                    state_n = ST_WB;
                end else begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_WB: begin
                done    = 1'b1;
                err     = dec_q.illegal;
                state_n = ST_IDLE;
                if (dec_q.da_sel == DA_RT)       dst = rt_q;
                else if (dec_q.da_sel == DA_R31) dst = LINK_REG;
                if (dec_q.wr_en) begin
                    Y_Sel  = dec_q.y_sel;
                    DA_sel = dec_q.da_sel;
                    D_Addr = dst;
                    // Writes to R0 are dropped; R31 is never zero.
                    D_En   = (dst != 5'd0);
                end
                if (dec_q.y_sel == Y_DY) DY    = imm_q;
                if (dec_q.y_sel == Y_PC) PC_in = pc_q;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
